// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the load-use hazard scoreboard: register file geometry,
// load latency defaults and the instruction used to flush IF/ID.
package hazard_scoreboard_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int LOAD_LAT_DEF = 1;
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 7;

  // addi x0, x0, 0 -- the canonical NOP written into IF/ID on a flush
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic int pend_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry_cnt.sv
// One register's load-pending countdown: reloads on a load issue, otherwise
// counts down to zero and sticks there.
module sb_entry_cnt #(
  parameter int LOAD_LAT = 1,
  parameter int PW       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic pend_o
);

  logic [PW-1:0] cnt_q, cnt_d;

  // A fresh load wins over the decrement of an older, still-pending one
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = PW'(LOAD_LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pend_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detection for an in-order pipeline: per-register pending
// counters, stall/flush steering and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              branch_taken,
  output logic              PC_write,
  output logic              ifid_write,
  output logic              ctrl_hazard,
  output logic              if_flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int NREG = 2 ** REG_AW;
  localparam int PW   = pend_width(LOAD_LAT);

  logic [NREG-1:0]  pend_vec;
  logic             raw, stall, issue, load_set;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // x0 never holds a loaded value, so it has no counter at all
  assign pend_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
      sb_entry_cnt #(
        .LOAD_LAT(LOAD_LAT),
        .PW      (PW)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(load_set && (id_rd == REG_AW'(gi))),
        .pend_o(pend_vec[gi])
      );
    end
  endgenerate

  assign raw = id_valid &&
               ((id_rs1_used && (id_rs1 != '0) && pend_vec[id_rs1]) ||
                (id_rs2_used && (id_rs2 != '0) && pend_vec[id_rs2]));

  // A taken branch squashes the ID instruction, so it can neither stall nor issue
  assign stall    = raw && !branch_taken;
  assign issue    = id_valid && !raw && !branch_taken;
  assign load_set = issue && id_memRead && id_regWrite && (id_rd != '0);

  assign PC_write    = !stall;
  assign ifid_write  = !stall;
  assign ctrl_hazard = stall || branch_taken;
  assign if_flush    = branch_taken;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: two scoreboards (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=4) on shared
// stimulus, checked against a register-availability-time reference model.
module tb_hazard_scoreboard;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       bt;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_regWrite = 1'b0, id_memRead = 1'b0, branch_taken = 1'b0;

  logic        pcw1, ifw1, ch1, fl1, pcw3, ifw3, ch3, fl3;
  logic [15:0] cnt1;
  logic [3:0]  cnt3;
  logic [3:0]  flags1, flags3;

  assign flags1 = {pcw1, ifw1, ch1, fl1};
  assign flags3 = {pcw3, ifw3, ch3, fl3};

  int checks = 0;
  int fails  = 0;

  // Reference model: cycle at which each register's loaded value becomes usable
  longint cyc = 0;
  longint av1[32];
  longint av3[32];
  int     mc1 = 0;
  int     mc3 = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(LAT1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .branch_taken(branch_taken),
    .PC_write(pcw1), .ifid_write(ifw1), .ctrl_hazard(ch1), .if_flush(fl1), .stall_cnt(cnt1)
  );

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(LAT3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .branch_taken(branch_taken),
    .PC_write(pcw3), .ifid_write(ifw3), .ctrl_hazard(ch3), .if_flush(fl3), .stall_cnt(cnt3)
  );

  function automatic instr_t mk_lw(input int rd, input int rs1);
    instr_t i = '0;
    i.v = 1'b1; i.rs1 = 5'(rs1); i.u1 = 1'b1; i.rd = 5'(rd); i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_alu(input int rd, input int a, input int b);
    instr_t i = '0;
    i.v = 1'b1; i.rs1 = 5'(a); i.rs2 = 5'(b); i.u1 = 1'b1; i.u2 = 1'b1;
    i.rd = 5'(rd); i.rw = 1'b1;
    return i;
  endfunction

  function automatic bit m_pend(input int w, input int r);
    if (r == 0) return 1'b0;
    return (w == 0) ? (cyc < av1[r]) : (cyc < av3[r]);
  endfunction

  function automatic bit m_raw(input int w);
    return id_valid && ((id_rs1_used && m_pend(w, int'(id_rs1))) ||
                        (id_rs2_used && m_pend(w, int'(id_rs2))));
  endfunction

  function automatic bit m_stall(input int w);
    return m_raw(w) && !branch_taken;
  endfunction

  function automatic bit m_issue(input int w);
    return id_valid && !m_raw(w) && !branch_taken;
  endfunction

  function automatic logic [3:0] exp_flags(input int w);
    bit st = m_stall(w);
    return {!st, !st, st || branch_taken, branch_taken};
  endfunction

  task automatic drive(input instr_t i, input logic rstn);
    @(negedge clk);
    rst_n = rstn;
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs1_used = i.u1; id_rs2_used = i.u2;
    id_rd = i.rd; id_regWrite = i.rw; id_memRead = i.mr; branch_taken = i.bt;
    #1;
  endtask

  // Advance one clock edge, moving the reference model in step with the DUTs
  task automatic tick();
    bit s0 = m_stall(0), s1 = m_stall(1);
    bit ld = id_memRead && id_regWrite && (id_rd != 0);
    bit i0 = m_issue(0) && ld, i1 = m_issue(1) && ld;
    @(posedge clk);
    if (!rst_n) begin
      foreach (av1[r]) begin av1[r] = 0; av3[r] = 0; end
      mc1 = 0; mc3 = 0;
    end else begin
      if (s0 && mc1 < 65535) mc1++;
      if (s1 && mc3 < 15) mc3++;
      if (i0) av1[id_rd] = cyc + 1 + LAT1;
      if (i1) av3[id_rd] = cyc + 1 + LAT3;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    drive('0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    drive('0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      instr_t i = mk_alu(6, 5, 7);
      i.bt = c[0];
      drive(i, 1'b0);
      checks += 2;
      if (flags1 !== {2'b11, c[0], c[0]} || cnt1 !== 16'd0) begin
        fails++;
        $display("FAIL reset[%0d] dut1 flags/cnt got %b/%0d want %b/0", c, flags1, cnt1, {2'b11, c[0], c[0]});
      end
      if (flags3 !== {2'b11, c[0], c[0]} || cnt3 !== 4'd0) begin
        fails++;
        $display("FAIL reset[%0d] dut3 flags/cnt got %b/%0d want %b/0", c, flags3, cnt3, {2'b11, c[0], c[0]});
      end
      tick();
    end
  endtask

  // Presents a program, holding each instruction in ID while the primary DUT stalls
  task automatic test_load_use();
    instr_t prog[3] = '{mk_lw(5, 1), mk_alu(6, 5, 1), mk_alu(7, 2, 3)};
    do_reset();
    foreach (prog[k]) begin
      int n = 0;
      bit st;
      do begin
        drive(prog[k], 1'b1);
        checks += 2;
        if (flags1 !== exp_flags(0) || cnt1 !== 16'(mc1)) begin
          fails++;
          $display("FAIL load_use[%0d] dut1 flags/cnt got %b/%0d want %b/%0d", k, flags1, cnt1, exp_flags(0), mc1);
        end
        if (flags3 !== exp_flags(1) || cnt3 !== 4'(mc3)) begin
          fails++;
          $display("FAIL load_use[%0d] dut3 flags/cnt got %b/%0d want %b/%0d", k, flags3, cnt3, exp_flags(1), mc3);
        end
        st = m_stall(0);
        tick();
        n++;
      end while (st && n < 16);
      checks++;
      if (st) begin fails++; $display("FAIL load_use timeout got stalled want issue"); end
    end
    checks++;
    if (cnt1 !== 16'd1) begin fails++; $display("FAIL load_use stall_cnt got %0d want 1", cnt1); end
  endtask

  task automatic test_load_gap();
    instr_t prog[3] = '{mk_lw(7, 1), mk_alu(8, 2, 3), mk_alu(9, 7, 1)};
    do_reset();
    foreach (prog[k]) begin
      int n = 0;
      bit st;
      do begin
        drive(prog[k], 1'b1);
        checks += 2;
        if (flags1 !== exp_flags(0) || cnt1 !== 16'(mc1)) begin
          fails++;
          $display("FAIL load_gap[%0d] dut1 flags/cnt got %b/%0d want %b/%0d", k, flags1, cnt1, exp_flags(0), mc1);
        end
        if (flags3 !== exp_flags(1) || cnt3 !== 4'(mc3)) begin
          fails++;
          $display("FAIL load_gap[%0d] dut3 flags/cnt got %b/%0d want %b/%0d", k, flags3, cnt3, exp_flags(1), mc3);
        end
        st = m_stall(1);
        tick();
        n++;
      end while (st && n < 16);
    end
    checks += 2;
    if (cnt3 !== 4'd2) begin fails++; $display("FAIL load_gap dut3 stall_cnt got %0d want 2", cnt3); end
    if (cnt1 !== 16'd0) begin fails++; $display("FAIL load_gap dut1 stall_cnt got %0d want 0", cnt1); end
  endtask

  task automatic test_no_hazard();
    instr_t prog[4] = '{mk_lw(0, 1), mk_alu(6, 0, 0), mk_alu(5, 1, 2), mk_alu(6, 5, 5)};
    do_reset();
    foreach (prog[k]) begin
      drive(prog[k], 1'b1);
      checks += 2;
      if (flags1 !== 4'b1100 || cnt1 !== 16'd0) begin
        fails++;
        $display("FAIL no_hazard[%0d] dut1 flags/cnt got %b/%0d want 1100/0", k, flags1, cnt1);
      end
      if (flags3 !== 4'b1100 || cnt3 !== 4'd0) begin
        fails++;
        $display("FAIL no_hazard[%0d] dut3 flags/cnt got %b/%0d want 1100/0", k, flags3, cnt3);
      end
      tick();
    end
  endtask

  task automatic test_branch_priority();
    instr_t br = mk_alu(6, 5, 1);
    br.bt = 1'b1;
    do_reset();
    drive(mk_lw(5, 1), 1'b1);
    tick();
    drive(br, 1'b1);
    checks += 2;
    if (flags1 !== 4'b1111) begin fails++; $display("FAIL branch dut1 flags got %b want 1111", flags1); end
    if (flags3 !== 4'b1111) begin fails++; $display("FAIL branch dut3 flags got %b want 1111", flags3); end
    tick();
    for (int n = 0; n < 3; n++) begin
      drive(mk_alu(6, 5, 1), 1'b1);
      checks += 2;
      if (flags1 !== exp_flags(0) || cnt1 !== 16'(mc1)) begin
        fails++;
        $display("FAIL branch_after[%0d] dut1 flags/cnt got %b/%0d want %b/%0d", n, flags1, cnt1, exp_flags(0), mc1);
      end
      if (flags3 !== exp_flags(1) || cnt3 !== 4'(mc3)) begin
        fails++;
        $display("FAIL branch_after[%0d] dut3 flags/cnt got %b/%0d want %b/%0d", n, flags3, cnt3, exp_flags(1), mc3);
      end
      tick();
    end
    checks += 2;
    if (cnt3 !== 4'd2) begin fails++; $display("FAIL branch dut3 stall_cnt got %0d want 2", cnt3); end
    if (cnt1 !== 16'd0) begin fails++; $display("FAIL branch dut1 stall_cnt got %0d want 0", cnt1); end
  endtask

  // Seven load/use pairs: 21 stall cycles on the 4-bit counter, 7 on the 16-bit one
  task automatic test_saturation();
    do_reset();
    for (int p = 0; p < 7; p++) begin
      drive(mk_lw(5, 1), 1'b1);
      tick();
      for (int n = 0; n < 4; n++) begin
        drive(mk_alu(6, 5, 1), 1'b1);
        checks++;
        if (flags3 !== exp_flags(1) || cnt3 !== 4'(mc3)) begin
          fails++;
          $display("FAIL saturate[%0d.%0d] dut3 flags/cnt got %b/%0d want %b/%0d", p, n, flags3, cnt3, exp_flags(1), mc3);
        end
        tick();
      end
    end
    checks += 2;
    if (cnt3 !== 4'd15) begin fails++; $display("FAIL saturate dut3 stall_cnt got %0d want 15", cnt3); end
    if (cnt1 !== 16'd7) begin fails++; $display("FAIL saturate dut1 stall_cnt got %0d want 7", cnt1); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(mk_lw(5, 1), 1'b1);
    tick();
    drive(mk_alu(6, 5, 1), 1'b1);
    tick();
    drive(mk_alu(6, 5, 1), 1'b0);
    checks++;
    if (flags3 !== 4'b0010) begin fails++; $display("FAIL mid_reset pre-edge dut3 flags got %b want 0010", flags3); end
    tick();
    drive(mk_alu(6, 5, 1), 1'b1);
    checks += 2;
    if (flags3 !== 4'b1100 || cnt3 !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset dut3 flags/cnt got %b/%0d want 1100/0", flags3, cnt3);
    end
    if (flags1 !== 4'b1100 || cnt1 !== 16'd0) begin
      fails++;
      $display("FAIL mid_reset dut1 flags/cnt got %b/%0d want 1100/0", flags1, cnt1);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      instr_t i;
      i.v   = ($urandom_range(0, 3) != 0);
      i.rs1 = 5'($urandom_range(0, 7));
      i.rs2 = 5'($urandom_range(0, 7));
      i.u1  = ($urandom_range(0, 3) != 0);
      i.u2  = ($urandom_range(0, 1) != 0);
      i.rd  = 5'($urandom_range(0, 7));
      i.rw  = ($urandom_range(0, 3) != 0);
      i.mr  = ($urandom_range(0, 2) == 0);
      i.bt  = ($urandom_range(0, 7) == 0);
      drive(i, 1'($urandom_range(0, 79) != 0));
      checks += 2;
      if (flags1 !== exp_flags(0) || cnt1 !== 16'(mc1)) begin
        fails++;
        $display("FAIL random[%0d] dut1 flags/cnt got %b/%0d want %b/%0d", c, flags1, cnt1, exp_flags(0), mc1);
      end
      if (flags3 !== exp_flags(1) || cnt3 !== 4'(mc3)) begin
        fails++;
        $display("FAIL random[%0d] dut3 flags/cnt got %b/%0d want %b/%0d", c, flags3, cnt3, exp_flags(1), mc3);
      end
      tick();
    end
  endtask

  initial begin
    foreach (av1[r]) begin av1[r] = 0; av3[r] = 0; end
    test_reset();
    test_load_use();
    test_load_gap();
    test_no_hazard();
    test_branch_priority();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
